// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared prescaler/phase timebase.
// Duty writes go to per-channel shadow registers that load into the active registers at period boundaries.
module pwm_multi #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PWM_FREQ = 10_000,
    parameter int RES_BITS = 4,
    parameter int N_CH     = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           en,
    input  logic                                           wr_en,
    input  logic [(($clog2(N_CH) > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
    input  logic [RES_BITS:0]                              wr_duty,
    output logic                                           tick,
    output logic                                           period_start,
    output logic [N_CH-1:0]                                pwm_out
);

    localparam int STEP_RAW    = CLK_FREQ / (PWM_FREQ * (2 ** RES_BITS));
    localparam int STEP_CYCLES = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int PW          = ($clog2(STEP_CYCLES) > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [RES_BITS:0] DUTY_MAX   = {1'b1, {RES_BITS{1'b0}}};

    logic [PW-1:0]       presc;
    logic [RES_BITS-1:0] phase;
    logic [RES_BITS:0]   shadow [N_CH];
    logic [RES_BITS:0]   active [N_CH];
    logic [RES_BITS:0]   wr_sat;
    logic [N_CH-1:0]     wr_sel;

    always_comb begin
        tick         = en && (presc == PRESC_LAST);
        period_start = tick && (phase == '1);
        wr_sat       = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;
        wr_sel       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wr_sel[i] = wr_en && (32'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            presc <= '0;
            phase <= '0;
        end else if (tick) begin
            presc <= '0;
            phase <= phase + RES_BITS'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // The write bypass keeps active equal to the freshly written value both while
    // idle and when a write lands exactly on the period boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (wr_sel[i]) begin
                    shadow[i] <= wr_sat;
                end
                if (!en || period_start) begin
                    active[i] <= wr_sel[i] ? wr_sat : shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            pwm_out <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                pwm_out[i] <= ({1'b0, phase} < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: timebase, duty sweep, shadow update, collision,
// saturation, illegal channel, enable and reset behaviour.
module tb_pwm_multi;

    localparam int CLK_FREQ = 1_600_000;
    localparam int PWM_FREQ = 10_000;
    localparam int RES_BITS = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, wr_en;
    logic [1:0] wr_ch;
    logic [4:0] wr_duty;
    logic       tick, period_start;
    logic [3:0] pwm_out;

    // Second instance with a 3-bit channel index so out-of-range indices are representable
    logic       wr_en5;
    logic [2:0] wr_ch5;
    logic [4:0] wr_duty5;
    logic       tick5, ps5;
    logic [4:0] pwm_out5;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt  [4];
    int cnt5 [5];

    always #5 clk = ~clk;

    pwm_multi #(.CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .RES_BITS(RES_BITS), .N_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .tick(tick), .period_start(period_start), .pwm_out(pwm_out)
    );

    pwm_multi #(.CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .RES_BITS(RES_BITS), .N_CH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en5), .wr_ch(wr_ch5), .wr_duty(wr_duty5),
        .tick(tick5), .period_start(ps5), .pwm_out(pwm_out5)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int duty);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 5'(duty);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wr5(input int ch, input int duty);
        wr_en5 = 1'b1; wr_ch5 = 3'(ch); wr_duty5 = 5'(duty);
        step(1);
        wr_en5 = 1'b0;
    endtask

    task automatic wait_ps();
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (period_start) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        chk("period_start_seen", 32'(found), 32'd1);
    endtask

    // Counts high cycles of one full period. Starts one cycle after a period_start
    // sample; ends on the first cycle of the next period, ready for at_s1=1.
    task automatic measure(input bit at_s1, input int wr_at, input int ch, input int duty);
        if (!at_s1) begin
            wait_ps();
            step(1);
        end
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        for (int j = 0; j < 5; j++) cnt5[j] = 0;
        for (int k = 0; k < 160; k++) begin
            step(1);
            for (int j = 0; j < 4; j++) cnt[j] += int'(pwm_out[j]);
            for (int j = 0; j < 5; j++) cnt5[j] += int'(pwm_out5[j]);
            if (k == wr_at) begin
                wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = 5'(duty);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
        wr_en5 = 1'b0; wr_ch5 = '0; wr_duty5 = '0;
        step(3);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_period_start", 32'(period_start), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        rst_n = 1'b1;
        step(1);

        wr(0, 0); wr(1, 1); wr(2, 8); wr(3, 16);
        wr5(0, 2); wr5(1, 4); wr5(2, 6); wr5(3, 8); wr5(4, 10);
        wr5(5, 16); wr5(7, 16);
        chk("idle_pwm", 32'(pwm_out), 32'd0);

        // Timebase
        en = 1'b1;
        step(8);
        chk("tick_early", 32'(tick), 32'd0);
        step(1);
        chk("tick_first", 32'(tick), 32'd1);
        chk("tick5_first", 32'(tick5), 32'd1);
        chk("ps_not_first_tick", 32'(period_start), 32'd0);
        step(1);
        chk("tick_one_cycle", 32'(tick), 32'd0);
        step(139);
        chk("tick_15th", 32'(tick), 32'd1);
        chk("ps_15th", 32'(period_start), 32'd0);
        step(10);
        chk("tick_16th", 32'(tick), 32'd1);
        chk("ps_16th", 32'(period_start), 32'd1);
        chk("ps5_16th", 32'(ps5), 32'd1);

        // Duty sweep plus out-of-range channel writes on the 5-channel instance
        measure(1'b0, -1, 0, 0);
        chk("sweep_ch0", cnt[0], 0);
        chk("sweep_ch1", cnt[1], 10);
        chk("sweep_ch2", cnt[2], 80);
        chk("sweep_ch3", cnt[3], 160);
        chk("ill_ch0", cnt5[0], 20);
        chk("ill_ch1", cnt5[1], 40);
        chk("ill_ch2", cnt5[2], 60);
        chk("ill_ch3", cnt5[3], 80);
        chk("ill_ch4", cnt5[4], 100);

        // Shadow update: active 4, write 12 mid-period
        wr(1, 4);
        measure(1'b0, 60, 1, 12);
        chk("shadow_cur_ch1", cnt[1], 40);
        measure(1'b1, 158, 2, 5);
        chk("shadow_next_ch1", cnt[1], 120);
        chk("collide_cur_ch2", cnt[2], 80);
        measure(1'b1, 50, 0, 31);
        chk("collide_next_ch2", cnt[2], 50);
        chk("sat_cur_ch0", cnt[0], 0);
        chk("steady_ch3", cnt[3], 160);
        measure(1'b1, -1, 0, 0);
        chk("sat_next_ch0", cnt[0], 160);
        chk("sat_hold_ch1", cnt[1], 120);

        // Enable drop and restart
        step(60);
        chk("pre_drop_pwm", 32'(pwm_out), 32'b1011);
        en = 1'b0;
        step(1);
        chk("drop_pwm", 32'(pwm_out), 32'd0);
        chk("drop_tick", 32'(tick), 32'd0);
        step(25);
        chk("idle_hold_pwm", 32'(pwm_out), 32'd0);
        chk("idle_hold_ps", 32'(period_start), 32'd0);
        en = 1'b1;
        step(1);
        chk("restart_pwm", 32'(pwm_out), 32'b1111);
        step(148);
        chk("restart_tick15", 32'(tick), 32'd1);
        chk("restart_ps15", 32'(period_start), 32'd0);
        step(10);
        chk("restart_ps16", 32'(period_start), 32'd1);
        measure(1'b0, -1, 0, 0);
        chk("restart_ch0", cnt[0], 160);
        chk("restart_ch1", cnt[1], 120);
        chk("restart_ch2", cnt[2], 50);
        chk("restart_ch3", cnt[3], 160);

        // Reset mid-period
        step(40);
        chk("pre_rst_pwm", 32'(pwm_out), 32'b1111);
        rst_n = 1'b0;
        step(1);
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_ps", 32'(period_start), 32'd0);
        rst_n = 1'b1;
        measure(1'b0, -1, 0, 0);
        chk("post_rst_ch0", cnt[0], 0);
        chk("post_rst_ch1", cnt[1], 0);
        chk("post_rst_ch2", cnt[2], 0);
        chk("post_rst_ch3", cnt[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ, default 10_000, meaning PWM period frequency in Hz.
REQ-003 SHALL have parameter RES_BITS, default 4, meaning duty resolution; one period = 2^RES_BITS steps.
REQ-004 SHALL have parameter N_CH, default 4, meaning number of independent PWM channels.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-007 SHALL have port en, input, 1, meaning run enable.
REQ-008 SHALL have port wr_en, input, 1, meaning duty write strobe.
REQ-009 SHALL have port wr_ch, input, max($clog2(N_CH),1), meaning target channel index.
REQ-010 SHALL have port wr_duty, input, RES_BITS+1, meaning duty in steps (0 to 2^RES_BITS).
REQ-011 SHALL have port tick, output, 1, meaning step pulse.
REQ-012 SHALL have port period_start, output, 1, meaning period-boundary pulse.
REQ-013 SHALL have port pwm_out, output, N_CH, meaning registered PWM outputs.

Function
REQ-014 SHALL compute STEP_CYCLES = CLK_FREQ / (PWM_FREQ * 2^RES_BITS), integer division, clamped to a minimum of 1.
REQ-015 SHALL size the prescaler width as max($clog2(STEP_CYCLES),1).
REQ-016 While en=1, the prescaler SHALL count 0..STEP_CYCLES-1 and then wrap to 0.
REQ-017 tick SHALL be combinational: 1 exactly when en=1 and prescaler = STEP_CYCLES-1.
REQ-018 The RES_BITS-wide phase counter SHALL increment on each tick and wrap from 2^RES_BITS-1 to 0.
REQ-019 period_start SHALL be 1 when tick=1 and phase = 2^RES_BITS-1, i.e. the cycle of the phase wrap.
REQ-020 Each channel SHALL hold a shadow duty register and an active duty register, each RES_BITS+1 wide.
REQ-021 A write (wr_en=1 with wr_ch < N_CH) SHALL load the shadow duty of channel wr_ch on the next edge.
REQ-022 A write with wr_ch >= N_CH SHALL be ignored.
REQ-023 wr_duty > 2^RES_BITS SHALL saturate to 2^RES_BITS when stored.
REQ-024 On a period_start cycle, every active register SHALL load its shadow; mid-period writes never alter the current period (glitch-free update).
REQ-025 If a write coincides with period_start, the addressed active register SHALL load the newly written (saturated) value directly, bypassing the shadow.
REQ-026 pwm_out[i] SHALL be registered as (phase < active[i]) and therefore lag the phase by 1 cycle.
REQ-027 Duty 0 SHALL keep the output constantly low; duty 2^RES_BITS SHALL keep it constantly high, with no glitches at the period boundary.
REQ-028 While en=0:
 - prescaler and phase held at 0;
 - tick, period_start and pwm_out forced to 0;
 - active registers follow the shadows every cycle;
 - writes are still accepted.
REQ-029 When en rises, counting SHALL start from prescaler=0, phase=0, using the active duties already loaded.
REQ-030 Behaviour SHALL hold for any N_CH >= 1, RES_BITS >= 1 and STEP_CYCLES >= 1.

Reset
REQ-031 On rst_n=0 at a clock edge:
 - prescaler, phase, all shadow and all active registers cleared to 0;
 - pwm_out = 0, tick = 0, period_start = 0.
REQ-032 Reset SHALL take priority over en and wr_en.
REQ-033 Reset mid-period SHALL abort the period with no residual output pulse.

Verification (CLK_FREQ=1_600_000, PWM_FREQ=10_000, RES_BITS=4, N_CH=4 -> STEP_CYCLES=10, period=160 clk)
REQ-034 Timebase: en=1 after reset -> tick every 10 clk; period_start every 160 clk, coincident with the 16th tick.
REQ-035 Duty sweep: duties 0, 1, 8, 16 on ch0..ch3 -> high time per period 0, 10, 80, 160 clk; ch3 never drops, ch0 never rises.
REQ-036 Shadow update: write ch1=12 mid-period while active=4 -> current period stays 40 clk high; next period 120 clk high.
REQ-037 Collision and illegal writes: write ch2=5 in the period_start cycle -> that new period is 50 clk high. wr_ch=5 -> no register changes. wr_duty=31 -> stored as 16.
REQ-038 Enable and reset: drop en mid-period -> outputs 0 next cycle; re-raise en -> period restarts from phase 0. Pulse rst_n=0 mid-period -> all outputs 0 and all duties 0 afterwards.
